// File: rtl/input_debounce.sv
// input_debounce: per-channel 2-flop synchronizer, debounce counter and
// stable-level tracker with registered one-cycle rise/fall pulses.
// Optional build macro INPUT_DEBOUNCE_BYPASS_EN removes the counters and
// follows the synchronized input directly (3-edge latency).
module input_debounce #(
  parameter int P_WIDTH     = 8,
  parameter int P_DB_CYCLES = 1000000
) (
  input  logic               I_CLK_100MHZ,
  input  logic               I_RST_N,
  input  logic [P_WIDTH-1:0] I_RAW,
  output logic [P_WIDTH-1:0] O_LEVEL,
  output logic [P_WIDTH-1:0] O_RISE,
  output logic [P_WIDTH-1:0] O_FALL,
  output logic               O_ANY_RISE
);

  if (P_DB_CYCLES < 2) begin : g_param_check
    $error("input_debounce: P_DB_CYCLES must be >= 2");
  end

  logic [P_WIDTH-1:0] s1_q, s2_q;
  logic [P_WIDTH-1:0] rise_q, fall_q;
  logic [P_WIDTH-1:0] rise_d, fall_d;
  logic               any_rise_q;

  // Two-flop synchronizer on every raw pin
  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= I_RAW;
      s2_q <= s1_q;
    end
  end

`ifdef INPUT_DEBOUNCE_BYPASS_EN

  logic [P_WIDTH-1:0] level_q;

  // Edge detect on the synchronized input against its registered copy
  always_comb begin
    rise_d = s2_q & ~level_q;
    fall_d = ~s2_q & level_q;
  end

  // Registered level follows s2 one edge later
  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      level_q <= '0;
    end else begin
      level_q <= s2_q;
    end
  end

  assign O_LEVEL = level_q;

`else

  localparam int P_CNT_W = $clog2(P_DB_CYCLES);
  localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_DB_CYCLES - 1);

  // State encodes {stable level, pending}
  typedef enum logic [1:0] {
    S_LO_STABLE = 2'b00,
    S_LO_PEND   = 2'b01,
    S_HI_STABLE = 2'b10,
    S_HI_PEND   = 2'b11
  } state_e;

  state_e             state_q [P_WIDTH];
  state_e             state_d [P_WIDTH];
  logic [P_CNT_W-1:0] cnt_q   [P_WIDTH];
  logic [P_CNT_W-1:0] cnt_d   [P_WIDTH];
  logic [P_WIDTH-1:0] lvl_cur, pend_cur, lvl_d;

  // Unpack state fields per channel
  always_comb begin
    lvl_cur  = '0;
    pend_cur = '0;
    for (int unsigned i = 0; i < P_WIDTH; i++) begin
      lvl_cur[i]  = state_q[i][1];
      pend_cur[i] = state_q[i][0];
    end
  end

  // Next state, counter and pulses. The pending bit is computed from s1
  // (the next s2) so it always equals s2 != level in the current cycle;
  // that keeps acceptance at k+1+P_DB_CYCLES and makes the "s2 still
  // differs" acceptance condition implicit in being pending.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    lvl_d  = lvl_cur;
    for (int unsigned i = 0; i < P_WIDTH; i++) begin
      cnt_d[i]   = '0;
      state_d[i] = state_q[i];
      if (pend_cur[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + P_CNT_W'(1);
        end
      end
      state_d[i] = state_e'({lvl_d[i], s1_q[i] != lvl_d[i]});
    end
  end

  // Per-channel state and counter registers
  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      for (int unsigned i = 0; i < P_WIDTH; i++) begin
        state_q[i] <= S_LO_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < P_WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign O_LEVEL = lvl_cur;

`endif

  // Registered one-cycle pulses and their OR-reduction
  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      rise_q     <= '0;
      fall_q     <= '0;
      any_rise_q <= 1'b0;
    end else begin
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_rise_q <= |rise_d;
    end
  end

  assign O_RISE     = rise_q;
  assign O_FALL     = fall_q;
  assign O_ANY_RISE = any_rise_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with P_DB_CYCLES=16.
// Inputs change 1 ns after a rising edge; the next edge is the sampling
// edge k, and after j calls of step() the bench sits 1 ns past edge k+j-1,
// so an acceptance at edge k+17 is observed at j=18.
module tb_input_debounce;
  localparam int W = 8;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level, rise, fall;
  logic         any_rise;

  int tests = 0;
  int fails = 0;

  input_debounce #(.P_WIDTH(W), .P_DB_CYCLES(N)) dut (
    .I_CLK_100MHZ(clk),
    .I_RST_N     (rst_n),
    .I_RAW       (raw),
    .O_LEVEL     (level),
    .O_RISE      (rise),
    .O_FALL      (fall),
    .O_ANY_RISE  (any_rise)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    raw   = '0;
    #50;
    tests++;
    if ({level, rise, fall, any_rise} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h/%h/%h/%b expected 0", level, rise, fall, any_rise);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 200; j++) begin
      step();
      if ({level, rise, fall, any_rise} !== '0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle_quiet: got %0d nonzero cycles expected 0", bad);
    end
  endtask

  task automatic test_clean_press();
    raw[0] = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      step();
      if (j == 17) begin
        tests++;
        if (level !== 8'h00 || rise !== 8'h00) begin
          fails++;
          $display("FAIL press_early: got level=%h rise=%h expected 00/00", level, rise);
        end
      end
      if (j == 18) begin
        tests++;
        if (level !== 8'h01 || rise !== 8'h01 || any_rise !== 1'b1 || fall !== 8'h00) begin
          fails++;
          $display("FAIL press_accept: got level=%h rise=%h any=%b fall=%h expected 01/01/1/00",
                   level, rise, any_rise, fall);
        end
      end
      if (j == 19) begin
        tests++;
        if (level !== 8'h01 || rise !== 8'h00 || any_rise !== 1'b0) begin
          fails++;
          $display("FAIL press_pulse_end: got level=%h rise=%h any=%b expected 01/00/0",
                   level, rise, any_rise);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int j = 0; j < 60; j++) begin
      raw[1] = ((j / 5) % 2 == 0);
      step();
      if (level[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0) bad++;
    end
    for (int j = 0; j < 20; j++) begin
      step();
      if (level[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL bounce_reject: got %0d bad cycles expected 0", bad);
    end
    raw[1] = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      step();
      if (j == 17) begin
        tests++;
        if (level !== 8'h01) begin
          fails++;
          $display("FAIL bounce_hold_early: got level=%h expected 01", level);
        end
      end
      if (j == 18) begin
        tests++;
        if (level !== 8'h03 || rise !== 8'h02) begin
          fails++;
          $display("FAIL bounce_hold_accept: got level=%h rise=%h expected 03/02", level, rise);
        end
      end
    end
  endtask

  task automatic test_release();
    int any_seen;
    any_seen = 0;
    raw[7] = 1'b1;
    for (int j = 1; j <= 18; j++) step();
    tests++;
    if (level !== 8'h83 || rise !== 8'h80) begin
      fails++;
      $display("FAIL ch7_press: got level=%h rise=%h expected 83/80", level, rise);
    end
    step();
    raw[7] = 1'b0;
    for (int j = 1; j <= 19; j++) begin
      step();
      if (any_rise !== 1'b0) any_seen++;
      if (j == 17) begin
        tests++;
        if (level !== 8'h83 || fall !== 8'h00) begin
          fails++;
          $display("FAIL release_early: got level=%h fall=%h expected 83/00", level, fall);
        end
      end
      if (j == 18) begin
        tests++;
        if (level !== 8'h03 || fall !== 8'h80 || rise !== 8'h00) begin
          fails++;
          $display("FAIL release_accept: got level=%h fall=%h rise=%h expected 03/80/00",
                   level, fall, rise);
        end
      end
      if (j == 19) begin
        tests++;
        if (fall !== 8'h00) begin
          fails++;
          $display("FAIL release_pulse_end: got fall=%h expected 00", fall);
        end
      end
    end
    tests++;
    if (any_seen !== 0) begin
      fails++;
      $display("FAIL release_no_any_rise: got %0d cycles expected 0", any_seen);
    end
  endtask

  task automatic test_glitch_boundary();
    int bad;
    bad = 0;
    // 15 samples high: one short of acceptance
    raw[3] = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j == 15) raw[3] = 1'b0;
      if (level[3] !== 1'b0 || rise[3] !== 1'b0 || fall[3] !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL glitch_15: got %0d bad cycles expected 0", bad);
    end
    // 16 samples high: exactly enough, then it falls back 16 edges later
    raw[3] = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j == 16) raw[3] = 1'b0;
      if (j == 18) begin
        tests++;
        if (level !== 8'h0B || rise !== 8'h08) begin
          fails++;
          $display("FAIL glitch_16_rise: got level=%h rise=%h expected 0b/08", level, rise);
        end
      end
      if (j == 34) begin
        tests++;
        if (level !== 8'h03 || fall !== 8'h08) begin
          fails++;
          $display("FAIL glitch_16_fall: got level=%h fall=%h expected 03/08", level, fall);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({level, rise, fall, any_rise} !== '0) begin
      fails++;
      $display("FAIL async_reset: got level=%h rise=%h fall=%h expected 00/00/00", level, rise, fall);
    end
    raw = '0;
    for (int j = 0; j < 3; j++) step();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) step();
  endtask

  task automatic test_simultaneous();
    raw = 8'hFF;
    for (int j = 1; j <= 19; j++) begin
      step();
      if (j == 17) begin
        tests++;
        if (level !== 8'h00 || rise !== 8'h00) begin
          fails++;
          $display("FAIL all_early: got level=%h rise=%h expected 00/00", level, rise);
        end
      end
      if (j == 18) begin
        tests++;
        if (level !== 8'hFF || rise !== 8'hFF || any_rise !== 1'b1 || fall !== 8'h00) begin
          fails++;
          $display("FAIL all_rise: got level=%h rise=%h any=%b fall=%h expected ff/ff/1/00",
                   level, rise, any_rise, fall);
        end
      end
      if (j == 19) begin
        tests++;
        if (rise !== 8'h00 || any_rise !== 1'b0 || level !== 8'hFF) begin
          fails++;
          $display("FAIL all_rise_end: got level=%h rise=%h any=%b expected ff/00/0",
                   level, rise, any_rise);
        end
      end
    end
    raw = 8'h00;
    for (int j = 1; j <= 18; j++) step();
    tests++;
    if (level !== 8'h00 || fall !== 8'hFF || rise !== 8'h00 || any_rise !== 1'b0) begin
      fails++;
      $display("FAIL all_fall: got level=%h fall=%h rise=%h any=%b expected 00/ff/00/0",
               level, fall, rise, any_rise);
    end
    for (int j = 0; j < 4; j++) step();
  endtask

  task automatic test_reset_mid();
    int early;
    early = 0;
    raw[2] = 1'b1;
    // Counter reaches 10 after edge k+11
    for (int j = 1; j <= 12; j++) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({level, rise, fall, any_rise} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got level=%h rise=%h fall=%h expected 0", level, rise, fall);
    end
    for (int j = 0; j < 3; j++) step();
    rst_n = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      step();
      if (j < 18 && (level !== 8'h00 || rise !== 8'h00)) early++;
      if (j == 18) begin
        tests++;
        if (level !== 8'h04 || rise !== 8'h04 || any_rise !== 1'b1) begin
          fails++;
          $display("FAIL mid_reset_accept: got level=%h rise=%h any=%b expected 04/04/1",
                   level, rise, any_rise);
        end
      end
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL mid_reset_early: got %0d early cycles expected 0", early);
    end
  endtask

`ifdef INPUT_DEBOUNCE_BYPASS_EN
  task automatic test_bypass();
    raw[0] = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      if (j == 10) raw[0] = 1'b0;
      if (j == 2) begin
        tests++;
        if (level !== 8'h00) begin
          fails++;
          $display("FAIL bypass_early: got level=%h expected 00", level);
        end
      end
      if (j == 3) begin
        tests++;
        if (level !== 8'h01 || rise !== 8'h01 || any_rise !== 1'b1) begin
          fails++;
          $display("FAIL bypass_rise: got level=%h rise=%h any=%b expected 01/01/1",
                   level, rise, any_rise);
        end
      end
      if (j == 12) begin
        tests++;
        if (level !== 8'h01 || rise !== 8'h00) begin
          fails++;
          $display("FAIL bypass_hold: got level=%h rise=%h expected 01/00", level, rise);
        end
      end
      if (j == 13) begin
        tests++;
        if (level !== 8'h00 || fall !== 8'h01) begin
          fails++;
          $display("FAIL bypass_fall: got level=%h fall=%h expected 00/01", level, fall);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef INPUT_DEBOUNCE_BYPASS_EN
    test_bypass();
`else
    test_clean_press();
    test_bounce();
    test_release();
    test_glitch_boundary();
    test_async_reset();
    test_simultaneous();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Input conditioner for the board's push-buttons and slide switches; sits between the top-level I_BTN/I_SW pins and all user logic.
- Per channel it provides:
  - a 2-flop synchronizer;
  - a debounce counter with its own per-channel state machine;
  - a clean stable level, plus one-cycle press (rise) and release (fall) pulses.
- One instance covers all 8 inputs: {I_SW[3:0], I_BTN[3:0]} concatenated by the top.

Parameters:
- P_WIDTH, 8, number of independent input channels.
- P_DB_CYCLES, 1000000, consecutive clock cycles the synced input must differ from the stable level before it is accepted (10 ms at 100 MHz). Must be >= 2; elaboration fails otherwise.
- P_CNT_W, $clog2(P_DB_CYCLES), width of each channel counter (derived, not overridden).

Ports:
- I_CLK_100MHZ  input  1  system clock, 100 MHz
- I_RST_N  input  1  asynchronous active-low reset
- I_RAW  input  P_WIDTH  raw asynchronous pin levels
- O_LEVEL  output  P_WIDTH  debounced stable level per channel
- O_RISE  output  P_WIDTH  one-cycle pulse when a channel's O_LEVEL goes 0->1
- O_FALL  output  P_WIDTH  one-cycle pulse when a channel's O_LEVEL goes 1->0
- O_ANY_RISE  output  1  OR-reduction of O_RISE, registered with it (same cycle)

Behaviour:
- Reset (I_RST_N=0, asynchronous): all sync flops, counters, O_LEVEL, O_RISE, O_FALL and O_ANY_RISE go to 0 immediately. Release is used synchronously. After release, a channel with I_RAW=1 is reported as a normal press after the full latency.
- Synchronizer per channel: s1 <= I_RAW[i]; s2 <= s1.
- Per-channel state machine, state = {O_LEVEL[i], pending}:
  - STABLE (s2 == O_LEVEL[i]): counter held at 0.
  - PEND (s2 != O_LEVEL[i]): counter increments by 1 each cycle.
  - In PEND, if s2 returns to O_LEVEL[i] before acceptance: back to STABLE, counter cleared. There is no partial credit; bounces restart the count.
  - Acceptance: in PEND with counter == P_DB_CYCLES-1 and s2 still != O_LEVEL[i]:
    - O_LEVEL[i] <= s2 and counter <= 0;
    - O_RISE[i] <= s2 or O_FALL[i] <= ~s2, for exactly one cycle;
    - the channel returns to STABLE.
- Latency: for an I_RAW edge first sampled at clock edge k and held, O_LEVEL and the pulse change at edge k+1+P_DB_CYCLES.
- A glitch shorter than P_DB_CYCLES cycles, measured at s2, never changes O_LEVEL and produces no pulse.
- O_RISE and O_FALL:
  - registered; never both high on the same channel;
  - deassert on the cycle after assertion unless a new acceptance occurs. A new acceptance is impossible on the next cycle, since it needs >= 2 cycles.
- Channels are fully independent. Simultaneous acceptances on several channels give simultaneous pulses. O_ANY_RISE is high in the same cycle as any O_RISE bit.
- Counter never exceeds P_DB_CYCLES-1; there is no wrap-around.
- Reset asserted mid-count discards the pending count and the stable level, and suppresses any pulse.

Optional Feature:
- Macro: INPUT_DEBOUNCE_BYPASS_EN.
- When defined:
  - counters and state machines are not generated;
  - O_LEVEL = registered s2, i.e. I_RAW delayed by 3 edges including the sampling edge;
  - O_RISE/O_FALL pulse on s2 edges with the same 1-cycle width and the same reset values.
  - Used for fast simulation and testbenches with short button pulses.
- When undefined: full debounce as above.
- Port list is identical in both builds.

Test Plan:
- Reset then idle (all benches use P_DB_CYCLES=16): hold I_RAW=0x00, I_RST_N=0 for 50 ns then 1 -> all outputs 0 throughout; no pulses for 200 cycles.
- Clean press: I_RAW[0] 0->1 sampled at edge k, held -> O_LEVEL[0]=1 and O_RISE[0]=O_ANY_RISE=1 at edge k+17 only; O_RISE[0]=0 at k+18.
- Bounce reject: I_RAW[1] toggles 1/0 every 5 cycles for 60 cycles, then returns to 0 -> O_LEVEL[1] stays 0; no O_RISE[1]/O_FALL[1]. Then hold 1 -> rise exactly 17 edges after the last 0->1 sample.
- Release: after a clean press on channel 7 (I_SW[3]), drop I_RAW[7] to 0 at edge m -> O_FALL[7]=1 at m+17, O_LEVEL[7]=0; O_ANY_RISE stays 0.
- Simultaneous channels: I_RAW 0x00->0xFF at one edge -> O_RISE=0xFF, O_LEVEL=0xFF in the same cycle; O_ANY_RISE=1 for one cycle.
- Reset mid-count: press channel 2, assert I_RST_N=0 at count 10 for 3 cycles, release with I_RAW[2] still 1 -> rise occurs 17 edges after the first post-reset sampling edge, not earlier. Bypass build: 100 ns pulse on I_RAW[0] -> 10-cycle O_LEVEL[0] pulse after 3-edge latency.
